// File: rtl/scope_pkg.sv
// Shared constants and types for the scope overlay path (grid and trace stages).
package scope_pkg;

  localparam int X_LEFT       = 442;
  localparam int WAVE_LEN     = 1080;
  localparam int Y_BOT        = 1055;
  localparam int TRIG_LEVEL   = 128;
  localparam int TRIG_TIMEOUT = 65535;

  localparam logic [23:0] WAVE_COLOR = 24'h00FF00;

  typedef enum logic [1:0] {
    CAP_ARM     = 2'd0,
    CAP_CAPTURE = 2'd1,
    CAP_FULL    = 2'd2
  } cap_state_t;

  // Screen row of a sample: 0 sits on the bottom grid line, 255 on the top one.
  function automatic logic [11:0] sample_to_y(input logic [7:0] s);
    return 12'(Y_BOT) - {2'b00, s, 2'b00};
  endfunction

endpackage

// File: rtl/wave_display_if.sv
// Video-in / video-out / ADC sample bundle for the trace overlay stage.
interface wave_display_if;

  logic        i_hs;
  logic        i_vs;
  logic        i_de;
  logic [23:0] i_data;
  logic        adc_valid;
  logic [7:0]  adc_data;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic [23:0] o_data;

  modport master (
    output i_hs, i_vs, i_de, i_data, adc_valid, adc_data,
    input  o_hs, o_vs, o_de, o_data
  );

  modport slave (
    input  i_hs, i_vs, i_de, i_data, adc_valid, adc_data,
    output o_hs, o_vs, o_de, o_data
  );

endinterface

// File: rtl/wave_display_buffer.sv
// Ping-pong sample store: two 2048x8 banks, one write port, one registered read port.
module wave_buffer (
  input  logic        pclk,
  input  logic        wr_en,
  input  logic        wr_bank,
  input  logic [10:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        rd_bank,
  input  logic [10:0] rd_addr,
  output logic [7:0]  rd_data
);

  logic [7:0] mem [0:4095];

  // Sample write into the selected bank.
  always_ff @(posedge pclk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // One-cycle synchronous read from the selected bank.
  always_ff @(posedge pclk) begin
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/wave_display.sv
// Oscilloscope trace overlay: captures a triggered ADC record and draws it over grid video.
//
// state   | meaning
// ARM     | waiting for a rising crossing of TRIG_LEVEL or the sample timeout
// CAPTURE | writing the record into the back bank, one sample per adc_valid
// FULL    | record complete; waiting for frame start to swap banks
module wave_display
  import scope_pkg::*;
(
  input logic           pclk,
  input logic           rst_n,
  wave_display_if.slave vif
);

  logic        vs_d, de_d, vs_rise, de_fall;
  logic [11:0] x_cnt, y_cnt;

  cap_state_t  cap_state, cap_state_nxt;
  logic [10:0] wr_addr;
  logic [15:0] tmo_cnt;
  logic [7:0]  prev_smp;
  logic        bank_sel, disp_valid;
  logic        trig_hit, tmo_hit, arm_fire, last_wr;
  logic        buf_we;
  logic [10:0] buf_waddr;

  logic        in_win;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic        hs1, vs1, de1, win1, first1;
  logic [23:0] data1;
  logic [11:0] y1, y_cur, y_last, y_prev, y_lo, y_hi;
  logic        is_trace;

  assign vs_rise = vif.i_vs & ~vs_d;
  assign de_fall = de_d & ~vif.i_de;

  // Edge-detect history for vsync and data enable.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
    end else begin
      vs_d <= vif.i_vs;
      de_d <= vif.i_de;
    end
  end

  // Column counter: x of the pixel currently on i_data, cleared during blanking.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)        x_cnt <= 12'd0;
    else if (vif.i_de) x_cnt <= x_cnt + 12'd1;
    else               x_cnt <= 12'd0;
  end

  // Row counter: advances at the end of each active line, cleared at frame start.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)       y_cnt <= 12'd0;
    else if (vs_rise) y_cnt <= 12'd0;
    else if (de_fall) y_cnt <= y_cnt + 12'd1;
  end

  assign trig_hit = (prev_smp < 8'(TRIG_LEVEL)) && (vif.adc_data >= 8'(TRIG_LEVEL));
  assign tmo_hit  = (tmo_cnt == 16'(TRIG_TIMEOUT - 1));
  assign arm_fire = vif.adc_valid && (trig_hit || tmo_hit);
  assign last_wr  = (wr_addr == 11'(WAVE_LEN - 1));

  // Capture state register.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) cap_state <= CAP_ARM;
    else        cap_state <= cap_state_nxt;
  end

  // Capture next-state decode.
  always_comb begin
    cap_state_nxt = cap_state;
    case (cap_state)
      CAP_ARM:     if (arm_fire) cap_state_nxt = CAP_CAPTURE;
      CAP_CAPTURE: if (vif.adc_valid && last_wr) cap_state_nxt = CAP_FULL;
      CAP_FULL:    if (vs_rise) cap_state_nxt = CAP_ARM;
      default:     cap_state_nxt = CAP_ARM;
    endcase
  end

  // Capture outputs: back-bank write strobe and address (trigger sample lands at 0).
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = wr_addr;
    case (cap_state)
      CAP_ARM: begin
        buf_we    = arm_fire;
        buf_waddr = 11'd0;
      end
      CAP_CAPTURE: buf_we = vif.adc_valid;
      default: ;
    endcase
  end

  // Record bookkeeping: trigger history, timeout count, write pointer and bank swap.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      prev_smp   <= 8'd0;
      tmo_cnt    <= 16'd0;
      wr_addr    <= 11'd0;
      bank_sel   <= 1'b0;
      disp_valid <= 1'b0;
    end else begin
      if (vif.adc_valid && (cap_state != CAP_FULL)) prev_smp <= vif.adc_data;
      case (cap_state)
        CAP_ARM:
          if (vif.adc_valid) begin
            if (arm_fire) begin
              wr_addr <= 11'd1;
              tmo_cnt <= 16'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
        CAP_CAPTURE:
          if (vif.adc_valid) wr_addr <= wr_addr + 11'd1;
        CAP_FULL:
          if (vs_rise) begin
            bank_sel   <= ~bank_sel;
            disp_valid <= 1'b1;
            tmo_cnt    <= 16'd0;
          end
        default: ;
      endcase
    end
  end

  wave_buffer u_buf (
    .pclk    (pclk),
    .wr_en   (buf_we),
    .wr_bank (~bank_sel),
    .wr_addr (buf_waddr),
    .wr_data (vif.adc_data),
    .rd_bank (bank_sel),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign in_win  = (x_cnt >= 12'(X_LEFT)) && (x_cnt <= 12'(X_LEFT + WAVE_LEN - 1));
  assign rd_addr = 11'(x_cnt - 12'(X_LEFT));

  // Stage 1: carry timing, video and position alongside the RAM read.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      de1    <= 1'b0;
      data1  <= 24'd0;
      win1   <= 1'b0;
      first1 <= 1'b0;
      y1     <= 12'd0;
    end else begin
      hs1    <= vif.i_hs;
      vs1    <= vif.i_vs;
      de1    <= vif.i_de;
      data1  <= vif.i_data;
      win1   <= in_win;
      first1 <= (x_cnt == 12'(X_LEFT));
      y1     <= y_cnt;
    end
  end

  assign y_cur    = sample_to_y(rd_data);
  assign y_prev   = first1 ? y_cur : y_last;
  assign y_lo     = (y_prev < y_cur) ? y_prev : y_cur;
  assign y_hi     = (y_prev < y_cur) ? y_cur : y_prev;
  assign is_trace = disp_valid && de1 && win1 && (y1 >= y_lo) && (y1 <= y_hi);

  // Previous column's trace height, so steep edges draw as a vertical connector.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)            y_last <= 12'd0;
    else if (de1 && win1)  y_last <= y_cur;
  end

  // Stage 2: overlay trace colour and emit delayed timing.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vif.o_hs   <= 1'b0;
      vif.o_vs   <= 1'b0;
      vif.o_de   <= 1'b0;
      vif.o_data <= 24'd0;
    end else begin
      vif.o_hs   <= hs1;
      vif.o_vs   <= vs1;
      vif.o_de   <= de1;
      vif.o_data <= is_trace ? WAVE_COLOR : data1;
    end
  end

endmodule

// File: tb/tb_wave_display.sv
// Directed bench for wave_display: scoreboarded video stream with a reference trace model.
module tb_wave_display;

  localparam logic [23:0] GREEN = 24'h00FF00;
  localparam logic [23:0] BLANK = 24'h0A0B0C;

  logic pclk  = 1'b0;
  logic rst_n = 1'b0;

  always #5 pclk = ~pclk;

  wave_display_if vif ();

  wave_display dut (
    .pclk  (pclk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  typedef struct {
    logic [26:0] v;
    int          x;
    int          y;
  } exp_t;

  exp_t sb[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   adc_left  = 0;
  int   adc_idx   = 0;
  int   adc_kind  = 0;
  bit   exp_valid = 1'b0;
  int   exp_kind  = 0;
  int   row_y[$];
  int   row_w[$];

  function automatic logic [26:0] dut_out();
    return {vif.o_hs, vif.o_vs, vif.o_de, vif.o_data};
  endfunction

  // Displayed record: flat zeros, or a ramp captured from its 127->128 crossing.
  function automatic int rec(input int i);
    if (exp_kind == 1) return (128 + i) % 256;
    return 0;
  endfunction

  function automatic bit on_trace(input int x, input int y);
    int i, yc, yp, lo, hi;
    if (!exp_valid || x < 442 || x > 1521) return 1'b0;
    i  = x - 442;
    yc = 1055 - 4 * rec(i);
    yp = (i == 0) ? yc : 1055 - 4 * rec(i - 1);
    lo = (yc < yp) ? yc : yp;
    hi = (yc < yp) ? yp : yc;
    return (y >= lo) && (y <= hi);
  endfunction

  function automatic logic [23:0] pix(input int x, input int y);
    return {8'(x), 8'(y), 8'(x + y) | 8'h01};
  endfunction

  task automatic add_row(input int y, input int w);
    row_y.push_back(y);
    row_w.push_back(w);
  endtask

  task automatic step(input logic hs, input logic vs, input logic de,
                      input logic [23:0] d, input int x, input int y);
    exp_t        e;
    logic [26:0] got;
    @(negedge pclk);
    if (sb.size() >= 2) begin
      e   = sb.pop_front();
      got = dut_out();
      n_tests++;
      assert (got === e.v) else begin
        n_fail++;
        $error("FAIL video x=%0d y=%0d observed %h expected %h", e.x, e.y, got, e.v);
      end
    end
    vif.i_hs   = hs;
    vif.i_vs   = vs;
    vif.i_de   = de;
    vif.i_data = d;
    if (adc_left > 0) begin
      vif.adc_valid = 1'b1;
      vif.adc_data  = (adc_kind == 1) ? 8'(adc_idx) : 8'd0;
      adc_idx++;
      adc_left--;
    end else begin
      vif.adc_valid = 1'b0;
      vif.adc_data  = 8'd0;
    end
    e.v = {hs, vs, de, (de && on_trace(x, y)) ? GREEN : d};
    e.x = x;
    e.y = y;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, BLANK, -1, -1);
  endtask

  // Frame: vsync pulse, then lines that are one pixel wide unless listed in row_y/row_w.
  task automatic frame(input int nlines);
    int w;
    repeat (3) step(1'b0, 1'b1, 1'b0, BLANK, -1, -1);
    repeat (2) step(1'b0, 1'b0, 1'b0, BLANK, -1, -1);
    for (int j = 0; j < nlines; j++) begin
      w = 1;
      foreach (row_y[r]) if (row_y[r] == j) w = row_w[r];
      for (int k = 0; k < w; k++) step(1'b0, 1'b0, 1'b1, pix(k, j), k, j);
      step(1'b1, 1'b0, 1'b0, BLANK, -1, -1);
    end
    row_y.delete();
    row_w.delete();
  endtask

  initial begin
    logic [26:0] got;
    vif.i_hs      = 1'b0;
    vif.i_vs      = 1'b0;
    vif.i_de      = 1'b0;
    vif.i_data    = 24'd0;
    vif.adc_valid = 1'b0;
    vif.adc_data  = 8'd0;
    repeat (3) @(negedge pclk);

    got = dut_out();
    n_tests++;
    assert (got === 27'd0) else begin
      n_fail++;
      $error("FAIL reset_state observed %h expected %h", got, 27'd0);
    end
    rst_n = 1'b1;

    // Flat zero input: no trigger, forced capture after 65535 samples, 1079 more to fill.
    adc_kind = 0;
    adc_idx  = 0;
    adc_left = 66614;
    exp_valid = 1'b0;
    add_row(3, 1530);
    frame(6);
    idle(adc_left);
    // Record completed one cycle before this frame's vsync: swap happens now.
    exp_valid = 1'b1;
    exp_kind  = 0;
    add_row(1054, 600);
    add_row(1055, 1530);
    frame(1056);

    // Ramp: final capture write lands on the vsync rising cycle, so no swap this frame.
    adc_kind = 1;
    adc_idx  = 0;
    adc_left = 1208;
    idle(1207);
    add_row(543, 600);
    add_row(1055, 600);
    frame(1056);

    // Following frame shows the ramp record, including the 255->0 full-height connector.
    exp_kind = 1;
    add_row(35, 1530);
    add_row(542, 450);
    add_row(543, 1530);
    add_row(1055, 600);
    frame(1056);

    // Reset in the middle of a new capture.
    adc_kind = 1;
    adc_idx  = 0;
    adc_left = 600;
    idle(600);
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 1'b1, pix(k, 0), k, 0);
    got = dut_out();
    n_tests++;
    assert (got === {3'b001, pix(47, 0)}) else begin
      n_fail++;
      $error("FAIL pre_reset observed %h expected %h", got, {3'b001, pix(47, 0)});
    end
    #2 rst_n = 1'b0;
    #1 got = dut_out();
    n_tests++;
    assert (got === 27'd0) else begin
      n_fail++;
      $error("FAIL async_reset observed %h expected %h", got, 27'd0);
    end
    adc_left      = 0;
    vif.i_de      = 1'b0;
    vif.i_data    = 24'd0;
    vif.adc_valid = 1'b0;
    sb.delete();
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;

    // Old front bank still holds the ramp, but nothing may be drawn before a new swap.
    exp_valid = 1'b0;
    add_row(543, 600);
    frame(545);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
